// File: rtl/bmmio_pkg.sv
// Shared types and address-field constants for the MMIO bus bridge.
package bmmio_pkg;

    localparam int unsigned NSLOT      = 8;
    localparam int unsigned SLOT_LSB   = 9;
    localparam int unsigned SLOT_MSB   = 11;
    localparam int unsigned OFFSET_LSB = 2;
    localparam int unsigned OFFSET_MSB = 8;
    localparam int unsigned SLOT_W     = SLOT_MSB - SLOT_LSB + 1;
    localparam int unsigned OFFSET_W   = OFFSET_MSB - OFFSET_LSB + 1;
    localparam logic [31:0] MMIO_BASE  = 32'h0200_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_WDRAIN,
        ST_ACCESS,
        ST_RESP,
        ST_ERROR
    } state_e;

endpackage

// File: rtl/bus_mmio_if.sv
// Main-bus side of the MMIO bridge: command, write-data, read-data and error channels.
interface bus_mmio_if;

    logic        bmain_cvalid_bmmio;
    logic        bmmio_cready;
    logic        bmain_cmd;
    logic [27:2] bmain_addr;
    logic        bmain_wvalid_bmmio;
    logic        bmmio_wready;
    logic        bmain_wlast;
    logic [31:0] bmain_wdata;
    logic [3:0]  bmain_wmask;
    logic        bmmio_rvalid;
    logic        bmain_rready_bmmio;
    logic [31:0] bmmio_rdata;
    logic        bmmio_error;
    logic        bmain_eack_bmmio;

    modport master (
        output bmain_cvalid_bmmio, bmain_cmd, bmain_addr,
               bmain_wvalid_bmmio, bmain_wlast, bmain_wdata, bmain_wmask,
               bmain_rready_bmmio, bmain_eack_bmmio,
        input  bmmio_cready, bmmio_wready, bmmio_rvalid, bmmio_rdata, bmmio_error
    );

    modport slave (
        input  bmain_cvalid_bmmio, bmain_cmd, bmain_addr,
               bmain_wvalid_bmmio, bmain_wlast, bmain_wdata, bmain_wmask,
               bmain_rready_bmmio, bmain_eack_bmmio,
        output bmmio_cready, bmmio_wready, bmmio_rvalid, bmmio_rdata, bmmio_error
    );

endinterface

// File: rtl/bus_mmio.sv
// Single-beat MMIO bridge: decodes the 4 KiB window into 8 peripheral slots over sel/ack,
// with bus errors for unpopulated slots, peripheral timeout and multi-beat writes.
module bus_mmio
    import bmmio_pkg::*;
#(
    parameter logic [NSLOT-1:0] SLOT_MASK = 8'hff,
    parameter int unsigned      TIMEOUT   = 255
) (
    input  logic                         clk_core,
    input  logic                         reset,
    bus_mmio_if.slave                    bus,
    output logic [NSLOT-1:0]             bmmio_psel,
    output logic                         bmmio_pwe,
    output logic [OFFSET_MSB:OFFSET_LSB] bmmio_paddr,
    output logic [31:0]                  bmmio_pwdata,
    output logic [3:0]                   bmmio_pwmask,
    input  logic [NSLOT-1:0]             periph_ack,
    input  logic [32*NSLOT-1:0]          periph_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cready_q, cready_d;
    logic                wready_q, wready_d;
    logic                rvalid_q, rvalid_d;
    logic                error_q, error_d;
    logic [NSLOT-1:0]    psel_q, psel_d;
    logic                pwe_q, pwe_d;
    logic                cmd_q, cmd_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [OFFSET_W-1:0] off_q, off_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          wmask_q, wmask_d;
    logic [31:0]         rdata_q, rdata_d;

    logic                cmd_beat_c, w_beat_c, ack_hit_c, tmo_hit_c;
    logic [SLOT_W-1:0]   in_slot_c;
    logic                unused_addr_c;

    assign cmd_beat_c    = bus.bmain_cvalid_bmmio & cready_q;
    assign w_beat_c      = bus.bmain_wvalid_bmmio & wready_q;
    assign in_slot_c     = bus.bmain_addr[SLOT_MSB:SLOT_LSB];
    assign ack_hit_c     = periph_ack[slot_q];
    assign tmo_hit_c     = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign unused_addr_c = ^bus.bmain_addr[27:12];

    // Next state, latched transaction fields and next registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        slot_d  = slot_q;
        off_d   = off_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_beat_c) begin
                    cmd_d  = bus.bmain_cmd;
                    slot_d = in_slot_c;
                    off_d  = bus.bmain_addr[OFFSET_MSB:OFFSET_LSB];
                    if (!bus.bmain_cmd)          state_d = ST_WDATA;
                    else if (SLOT_MASK[in_slot_c]) state_d = ST_ACCESS;
                    else                         state_d = ST_ERROR;
                end
            end
            ST_WDATA: begin
                if (w_beat_c) begin
                    wdata_d = bus.bmain_wdata;
                    wmask_d = bus.bmain_wmask;
                    if (!bus.bmain_wlast)            state_d = ST_WDRAIN;
                    else if (!SLOT_MASK[slot_q])     state_d = ST_ERROR;
                    else if (bus.bmain_wmask == 4'h0) state_d = ST_IDLE;
                    else                             state_d = ST_ACCESS;
                end
            end
            ST_WDRAIN: begin
                if (w_beat_c && bus.bmain_wlast) state_d = ST_ERROR;
            end
            ST_ACCESS: begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                // An ack in the timeout cycle still completes the access.
                if (ack_hit_c) begin
                    if (cmd_q) begin
                        rdata_d = periph_rdata[{slot_q, 5'd0} +: 32];
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (tmo_hit_c) begin
                    state_d = ST_ERROR;
                end
            end
            ST_RESP: begin
                if (bus.bmain_rready_bmmio) state_d = ST_IDLE;
            end
            ST_ERROR: begin
                if (bus.bmain_eack_bmmio) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_ACCESS && state_q != ST_ACCESS) cnt_d = '0;

        cready_d = (state_d == ST_IDLE);
        wready_d = (state_d == ST_WDATA) || (state_d == ST_WDRAIN);
        rvalid_d = (state_d == ST_RESP);
        error_d  = (state_d == ST_ERROR);
        psel_d   = (state_d == ST_ACCESS) ? (NSLOT'(1) << slot_d) : '0;
        pwe_d    = (state_d == ST_ACCESS) && !cmd_d;
    end

    // Control state and handshake outputs.
    always_ff @(posedge clk_core) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            cready_q <= 1'b1;
            wready_q <= 1'b0;
            rvalid_q <= 1'b0;
            error_q  <= 1'b0;
            psel_q   <= '0;
            pwe_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cready_q <= cready_d;
            wready_q <= wready_d;
            rvalid_q <= rvalid_d;
            error_q  <= error_d;
            psel_q   <= psel_d;
            pwe_q    <= pwe_d;
        end
    end

    // Transaction data registers carry no reset.
    always_ff @(posedge clk_core) begin
        cmd_q   <= cmd_d;
        slot_q  <= slot_d;
        off_q   <= off_d;
        wdata_q <= wdata_d;
        wmask_q <= wmask_d;
        rdata_q <= rdata_d;
    end

    assign bus.bmmio_cready = cready_q;
    assign bus.bmmio_wready = wready_q;
    assign bus.bmmio_rvalid = rvalid_q;
    assign bus.bmmio_rdata  = rdata_q;
    assign bus.bmmio_error  = error_q;
    assign bmmio_psel       = psel_q;
    assign bmmio_pwe        = pwe_q;
    assign bmmio_paddr      = off_q;
    assign bmmio_pwdata     = wdata_q;
    assign bmmio_pwmask     = wmask_q;

endmodule

// File: tb/tb_bus_mmio.sv
// Bench for bus_mmio: two instances (full map / 4-slot map with short timeout) driven by
// directed and random transactions, checked against a transaction-level outcome model.
`timescale 1ns/1ps
module tb_bus_mmio;
    import bmmio_pkg::*;

    logic clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    logic        reset;
    logic        sel;
    logic        cvalid, cmd, wvalid, wlast, rready, eack;
    logic [27:2] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] pword [8];
    logic [255:0] prdata;

    bus_mmio_if if_a ();
    bus_mmio_if if_b ();

    logic [7:0]  psel_a, psel_b, ack_a, ack_b, ack_vec, noise;
    logic        pwe_a, pwe_b;
    logic [8:2]  paddr_a, paddr_b;
    logic [31:0] pwdata_a, pwdata_b;
    logic [3:0]  pwmask_a, pwmask_b;

    assign if_a.bmain_cvalid_bmmio = cvalid & ~sel;
    assign if_a.bmain_wvalid_bmmio = wvalid & ~sel;
    assign if_a.bmain_rready_bmmio = rready & ~sel;
    assign if_a.bmain_eack_bmmio   = eack & ~sel;
    assign if_a.bmain_cmd   = cmd;
    assign if_a.bmain_addr  = addr;
    assign if_a.bmain_wlast = wlast;
    assign if_a.bmain_wdata = wdata;
    assign if_a.bmain_wmask = wmask;
    assign if_b.bmain_cvalid_bmmio = cvalid & sel;
    assign if_b.bmain_wvalid_bmmio = wvalid & sel;
    assign if_b.bmain_rready_bmmio = rready & sel;
    assign if_b.bmain_eack_bmmio   = eack & sel;
    assign if_b.bmain_cmd   = cmd;
    assign if_b.bmain_addr  = addr;
    assign if_b.bmain_wlast = wlast;
    assign if_b.bmain_wdata = wdata;
    assign if_b.bmain_wmask = wmask;

    bus_mmio u_a (
        .clk_core(clk_core), .reset(reset), .bus(if_a),
        .bmmio_psel(psel_a), .bmmio_pwe(pwe_a), .bmmio_paddr(paddr_a),
        .bmmio_pwdata(pwdata_a), .bmmio_pwmask(pwmask_a),
        .periph_ack(ack_a), .periph_rdata(prdata)
    );

    bus_mmio #(.SLOT_MASK(8'h0f), .TIMEOUT(4)) u_b (
        .clk_core(clk_core), .reset(reset), .bus(if_b),
        .bmmio_psel(psel_b), .bmmio_pwe(pwe_b), .bmmio_paddr(paddr_b),
        .bmmio_pwdata(pwdata_b), .bmmio_pwmask(pwmask_b),
        .periph_ack(ack_b), .periph_rdata(prdata)
    );

    logic        o_cready, o_wready, o_rvalid, o_error, o_pwe;
    logic [31:0] o_rdata, o_pwdata;
    logic [7:0]  o_psel;
    logic [8:2]  o_paddr;
    logic [3:0]  o_pwmask;
    assign o_cready = sel ? if_b.bmmio_cready : if_a.bmmio_cready;
    assign o_wready = sel ? if_b.bmmio_wready : if_a.bmmio_wready;
    assign o_rvalid = sel ? if_b.bmmio_rvalid : if_a.bmmio_rvalid;
    assign o_rdata  = sel ? if_b.bmmio_rdata  : if_a.bmmio_rdata;
    assign o_error  = sel ? if_b.bmmio_error  : if_a.bmmio_error;
    assign o_psel   = sel ? psel_b   : psel_a;
    assign o_pwe    = sel ? pwe_b    : pwe_a;
    assign o_paddr  = sel ? paddr_b  : paddr_a;
    assign o_pwdata = sel ? pwdata_b : pwdata_a;
    assign o_pwmask = sel ? pwmask_b : pwmask_a;

    // Peripheral model: the selected slot acks after ack_delay select cycles; other slots babble.
    int cyc = 0;
    int acc_cnt = 0;
    int ack_delay = 0;
    always @(posedge clk_core) begin
        cyc     <= cyc + 1;
        acc_cnt <= (o_psel != 8'h0) ? acc_cnt + 1 : 0;
    end
    assign ack_vec = ((o_psel != 8'h0 && acc_cnt == ack_delay) ? o_psel : 8'h0) | (noise & ~o_psel);
    assign ack_a   = sel ? 8'h0 : ack_vec;
    assign ack_b   = sel ? ack_vec : 8'h0;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Access monitor: records the select window and requires the access outputs to hold.
    int          mon_n = 0, mon_first = 0, mon_last = 0;
    logic [7:0]  cap_psel;
    logic        cap_pwe;
    logic [8:2]  cap_paddr;
    logic [31:0] cap_pwdata;
    logic [3:0]  cap_pwmask;
    always @(negedge clk_core) begin
        if (o_psel != 8'h0) begin
            if (mon_n == 0) begin
                mon_first  = cyc;
                cap_psel   = o_psel;
                cap_pwe    = o_pwe;
                cap_paddr  = o_paddr;
                cap_pwdata = o_pwdata;
                cap_pwmask = o_pwmask;
            end else begin
                checks++;
                assert ({o_psel, o_pwe, o_paddr, o_pwdata, o_pwmask} ===
                        {cap_psel, cap_pwe, cap_paddr, cap_pwdata, cap_pwmask}) else begin
                    failures++;
                    $error("FAIL access_hold observed=%h/%h/%h expected=%h/%h/%h",
                           o_psel, o_paddr, o_pwdata, cap_psel, cap_paddr, cap_pwdata);
                end
            end
            mon_n++;
            mon_last = cyc;
        end
    end

    // Outcome model: 0 = clean completion, 1 = read response, 2 = bus error; e_n = select cycles.
    function automatic void model(input bit is_b, input bit rd, input int unsigned slot,
                                  input int nbeats, input logic [3:0] wm, input int delay,
                                  output int e_out, output int e_n);
        int unsigned populated;
        int tmo;
        populated = is_b ? 32'h0f : 32'hff;
        tmo       = is_b ? 4 : 255;
        e_n = 0;
        if (!rd && nbeats > 1)                   e_out = 2;
        else if (((populated >> slot) & 1) == 0) e_out = 2;
        else if (!rd && wm == 4'h0)              e_out = 0;
        else if (tmo != 0 && delay >= tmo) begin e_out = 2; e_n = tmo; end
        else begin e_out = rd ? 1 : 0; e_n = delay + 1; end
    endfunction

    task automatic load_prdata();
        for (int i = 0; i < 8; i++) prdata[32*i +: 32] = pword[i];
    endtask

    task automatic run_txn(input bit rd, input logic [31:0] baddr, input int nbeats,
                           input logic [31:0] wd, input logic [3:0] wm, input int delay,
                           input int hold, input logic [7:0] nz);
        int g, b, out, e_out, e_n, cmd_cyc, wb_cyc, end_cyc;
        int unsigned slot, off;
        logic [31:0] rd_val;
        slot = (baddr - MMIO_BASE) / 512;
        off  = ((baddr - MMIO_BASE) % 512) / 4;
        g = 0;
        while (!o_cready && g < 50) begin @(negedge clk_core); g++; end
        if (!o_cready) chk("idle_wait", 64'd0, 64'd1);
        load_prdata();
        mon_n = 0; ack_delay = delay; noise = nz;
        cvalid = 1'b1; cmd = rd; addr = baddr[27:2]; cmd_cyc = cyc;
        @(negedge clk_core);
        cvalid = 1'b0; addr = 26'($urandom);
        wb_cyc = cmd_cyc;
        if (!rd) begin
            b = 0; g = 0;
            while (b < nbeats && g < 40) begin
                if (o_wready) begin
                    wvalid = 1'b1; wlast = (b == nbeats - 1);
                    wdata = (b == 0) ? wd : $urandom;
                    wmask = (b == 0) ? wm : 4'hf;
                    wb_cyc = cyc; b++;
                end else wvalid = 1'b0;
                @(negedge clk_core); g++;
            end
            wvalid = 1'b0; wlast = 1'b0;
            if (b < nbeats) chk("wbeat_wait", 64'(b), 64'(nbeats));
        end
        out = -1; g = 0; rd_val = '0;
        while (out < 0 && g < 400) begin
            if (o_rvalid)      out = 1;
            else if (o_error)  out = 2;
            else if (o_cready) out = 0;
            else begin @(negedge clk_core); g++; end
        end
        end_cyc = cyc;
        if (out < 0) chk("outcome_wait", 64'd0, 64'd1);
        if (out == 1) begin
            rd_val = o_rdata;
            repeat (hold) begin
                @(negedge clk_core);
                chk("rvalid_hold", 64'(o_rvalid), 64'd1);
                chk("rdata_hold", 64'(o_rdata), 64'(rd_val));
            end
            rready = 1'b1; @(negedge clk_core); rready = 1'b0;
            chk("cready_after_resp", 64'(o_cready), 64'd1);
            chk("rvalid_after_resp", 64'(o_rvalid), 64'd0);
        end else if (out == 2) begin
            repeat (hold) begin
                @(negedge clk_core);
                chk("error_hold", 64'(o_error), 64'd1);
                chk("cready_in_error", 64'(o_cready), 64'd0);
            end
            eack = 1'b1; @(negedge clk_core); eack = 1'b0;
            chk("cready_after_eack", 64'(o_cready), 64'd1);
            chk("error_after_eack", 64'(o_error), 64'd0);
        end
        model(sel, rd, slot, nbeats, wm, delay, e_out, e_n);
        chk("outcome", 64'(out), 64'(e_out));
        chk("psel_cycles", 64'(mon_n), 64'(e_n));
        if (e_n > 0 && mon_n > 0) begin
            chk("psel", 64'(cap_psel), 64'(8'd1 << slot));
            chk("paddr", 64'(cap_paddr), 64'(off));
            chk("pwe", 64'(cap_pwe), 64'(!rd));
            chk("psel_latency", 64'(mon_first), 64'(wb_cyc + 1));
            chk("end_latency", 64'(end_cyc), 64'(mon_last + 1));
            if (!rd) begin
                chk("pwdata", 64'(cap_pwdata), 64'(wd));
                chk("pwmask", 64'(cap_pwmask), 64'(wm));
            end
            if (out == 1) chk("rdata", 64'(rd_val), 64'(pword[slot]));
        end
        if (e_n == 0) chk("noaccess_latency", 64'(end_cyc), 64'(wb_cyc + 1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; sel = 1'b0; cvalid = 1'b0; cmd = 1'b0; addr = '0;
        wvalid = 1'b0; wlast = 1'b0; wdata = '0; wmask = '0; rready = 1'b0; eack = 1'b0;
        noise = 8'h0;
        for (int i = 0; i < 8; i++) pword[i] = $urandom;
        load_prdata();
        repeat (3) @(negedge clk_core);
        chk("rst_cready", 64'(o_cready), 64'd1);
        chk("rst_wready", 64'(o_wready), 64'd0);
        chk("rst_rvalid", 64'(o_rvalid), 64'd0);
        chk("rst_error", 64'(o_error), 64'd0);
        chk("rst_psel", 64'(o_psel), 64'd0);
        chk("rst_pwe", 64'(o_pwe), 64'd0);
        sel = 1'b1; #1;
        chk("rst_b_cready", 64'(o_cready), 64'd1);
        chk("rst_b_psel", 64'(o_psel), 64'd0);
        sel = 1'b0;
        @(negedge clk_core); reset = 1'b0;
        @(negedge clk_core);

        // Read slot 2 offset 0x10, ack in first access cycle, response held 3 cycles.
        pword[2] = 32'hdeadbeef;
        run_txn(1'b1, 32'h0200_0440, 1, 32'h0, 4'h0, 0, 3, 8'h0);
        // Write slot 7 offset 1 with partial mask.
        run_txn(1'b0, 32'h0200_0e04, 1, 32'h1234_5678, 4'b0011, 0, 0, 8'h0);
        // Unpopulated slot, timeout with no ack, ack on the last allowed cycle.
        sel = 1'b1; #1;
        run_txn(1'b1, 32'h0200_0a00, 1, 32'h0, 4'h0, 0, 4, 8'h0);
        run_txn(1'b1, 32'h0200_0200, 1, 32'h0, 4'h0, 1000, 2, 8'h0);
        run_txn(1'b1, 32'h0200_0200, 1, 32'h0, 4'h0, 3, 0, 8'h0);
        run_txn(1'b0, 32'h0200_0604, 1, 32'hcafe_f00d, 4'hf, 3, 0, 8'h0);
        sel = 1'b0; #1;
        // Two-beat write, empty-mask write, acks from other slots.
        run_txn(1'b0, 32'h0200_0100, 2, 32'hAAAA_5555, 4'hf, 0, 1, 8'h0);
        run_txn(1'b0, 32'h0200_0300, 1, 32'h5555_AAAA, 4'h0, 0, 0, 8'h0);
        run_txn(1'b1, 32'h0200_0800, 1, 32'h0, 4'h0, 2, 1, 8'hff);

        // Reset in the middle of an access, then a normal read.
        mon_n = 0; ack_delay = 1000; noise = 8'h0;
        cvalid = 1'b1; cmd = 1'b1; addr = 26'h000_0080;
        @(negedge clk_core); cvalid = 1'b0;
        @(negedge clk_core);
        chk("mid_psel", 64'(o_psel), 64'h02);
        reset = 1'b1; @(negedge clk_core); reset = 1'b0;
        chk("mid_rst_psel", 64'(o_psel), 64'd0);
        chk("mid_rst_cready", 64'(o_cready), 64'd1);
        chk("mid_rst_error", 64'(o_error), 64'd0);
        run_txn(1'b1, 32'h0200_0204, 1, 32'h0, 4'h0, 1, 1, 8'h0);

        for (int t = 0; t < 40; t++) begin
            int unsigned s, o;
            int nb, dl;
            bit r;
            logic [3:0] m;
            sel = 1'($urandom_range(0, 1)); #1;
            r  = 1'($urandom_range(0, 1));
            s  = $urandom_range(0, 7);
            o  = $urandom_range(0, 127);
            nb = ($urandom_range(0, 5) == 0) ? $urandom_range(2, 3) : 1;
            m  = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
            dl = sel ? $urandom_range(0, 6) : $urandom_range(0, 5);
            for (int i = 0; i < 8; i++) pword[i] = $urandom;
            run_txn(r, MMIO_BASE + 32'(s * 512 + o * 4), nb, $urandom, m, dl,
                    $urandom_range(0, 3), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_mmio.md
Name: bus_mmio

Overview:
- Downstream slave of the main bus for the 0x02000000-0x02000fff MMIO window.
- Accepts single-beat read/write commands and fans them out to up to 8 register-style peripheral slots of 512 B each, over a simple sel/ack interface.
- Returns one read beat, with rlast implied.
- Raises a bus error for:
  - unpopulated slots,
  - peripheral timeout,
  - multi-beat writes.

Parameters:
- SLOT_MASK, 8'hff, bit i=1 means slot i is populated.
- TIMEOUT, 255, maximum cycles in ACCESS without an ack before an error is raised; 0 disables the timeout.

Ports:
- clk_core  in  1  core clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- bmain_cvalid_bmmio  in  1  command valid.
- bmmio_cready  out  1  command ready.
- bmain_cmd  in  1  1=read, 0=write.
- bmain_addr  in  26 [27:2]  word address; only [11:2] is used.
- bmain_wvalid_bmmio  in  1  write data valid.
- bmmio_wready  out  1  write data ready.
- bmain_wlast  in  1  last write beat.
- bmain_wdata  in  32  write data.
- bmain_wmask  in  4  byte enables.
- bmmio_rvalid  out  1  read data valid.
- bmain_rready_bmmio  in  1  read data ready.
- bmmio_rdata  out  32  read data.
- bmmio_error  out  1  access fault.
- bmain_eack_bmmio  in  1  error acknowledge.
- bmmio_psel  out  8  one-hot peripheral select.
- bmmio_pwe  out  1  peripheral write enable.
- bmmio_paddr  out  7 [8:2]  word offset within the slot.
- bmmio_pwdata  out  32  peripheral write data.
- bmmio_pwmask  out  4  peripheral byte enables.
- periph_ack  in  8  per-slot acknowledge.
- periph_rdata  in  256  per-slot read data; slot i occupies [32i+31:32i].

Behaviour:
- Reset: state=IDLE, timeout counter=0.
  - Outputs at reset: cready=1, wready=0, rvalid=0, error=0, psel=0, pwe=0.
  - Data registers are not reset.
- Slot decode: slot=addr[11:9], offset=addr[8:2].
  - A slot is valid if SLOT_MASK[slot]=1.
- Beats:
  - A command beat is cvalid&cready.
  - Write and read beats follow the same valid&ready rule.
- FSM states: IDLE, WDATA, WDRAIN, ACCESS, RESP, ERROR.
- IDLE:
  - cready=1; all other outputs are inactive.
  - On a command beat, latch cmd, slot and offset.
  - Read: go to ACCESS if the slot is valid, else ERROR.
  - Write: go to WDATA.
- WDATA:
  - wready=1.
  - On a beat, latch wdata and wmask, then:
    - wlast=0: go to WDRAIN.
    - slot invalid: go to ERROR.
    - wmask=0: go to IDLE; no peripheral access is made.
    - otherwise: go to ACCESS.
- WDRAIN:
  - wready=1.
  - Discard beats until the beat with wlast=1, then go to ERROR.
- ACCESS:
  - psel[slot]=1 and pwe=~cmd; paddr, pwdata and pwmask are driven from the latched registers.
  - These outputs are held stable until ack.
  - The counter increments every ACCESS cycle.
  - periph_ack[slot]=1 ends the access:
    - Read: latch periph_rdata[slot] and go to RESP.
    - Write: go to IDLE.
  - Acks from non-selected slots are ignored.
  - If TIMEOUT≠0, ack is absent and counter==TIMEOUT-1, go to ERROR; psel drops in the next cycle.
  - An ack in the same cycle as the timeout wins.
  - The counter clears on ACCESS entry.
- RESP:
  - rvalid=1 with rdata stable.
  - On rready go to IDLE.
- ERROR:
  - error=1, held until eack=1, then go to IDLE.
  - No rvalid is produced for a faulting read.
- Latency:
  - Read: command beat at cycle N, psel at N+1; with ack at N+1, rvalid at N+2.
  - Write: with command at N and wdata at N+1, psel at N+2.
- Concurrency:
  - Only one transaction is in flight; cready=0 outside IDLE.
  - A write beat that arrives during IDLE is not accepted until WDATA.
- Reset mid-operation: reset forces IDLE in the following cycle regardless of state; psel drops and pending data is lost.
- Counter width: $clog2(TIMEOUT+1), saturating; it never wraps.

Decomposition:
- Shared package bmmio_pkg contains:
  - the state enum;
  - NSLOT=8;
  - the SLOT_LSB=9, SLOT_MSB=11 and OFFSET field constants;
  - the MMIO base constant 32'h02000000.
- No sub-module; the timeout counter and the read-data mux are inline.

Test Plan:
- Read slot 2, offset 0x10 (addr 0x02000440); periph_ack[2] in the first ACCESS cycle with rdata 0xdeadbeef -> psel=8'h04, paddr=7'h10, pwe=0; rvalid exactly one cycle after psel, rdata=0xdeadbeef; with rready held low for 3 cycles, rvalid and rdata stay stable.
- Write 0x12345678 with mask 4'b0011 to addr 0x02000e04 -> psel=8'h80, paddr=1, pwe=1, pwdata and pwmask correct; return to IDLE, cready=1, the cycle after ack.
- SLOT_MASK=8'h0f, read of 0x02000a00 (slot 5) -> no psel, error=1 held for 4 cycles until eack, then cready=1.
- TIMEOUT=4, no ack -> psel high for exactly 4 cycles, then error=1.
  - Repeat with ack on the 4th cycle -> normal completion, no error.
- Write with two beats (first wlast=0) -> both beats accepted, no psel, error after the second beat.
- Reset asserted during ACCESS -> psel=0, cready=1 the next cycle; a subsequent read completes normally.
